// File: rtl/iq_source_switch_pkg.sv
// Shared definitions for the RX source selector and the RX control register map:
// FSM state encoding, mode bit positions and a width helper.
package iq_source_switch_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_MUTE = 1'b1
  } state_t;

  localparam int MODE_CONJ = 0;
  localparam int MODE_SWAP = 1;

  // Width needed to index n values, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iq_conj_swap.sv
// Combinational I/Q conditioning: optional saturating conjugate, then optional I/Q swap.
// Shared between the RX selector and the TX path.
module iq_conj_swap
  import iq_source_switch_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] re_i,
  input  logic [W-1:0] im_i,
  input  logic [1:0]   mode_i,
  output logic [W-1:0] re_o,
  output logic [W-1:0] im_o
);

  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};

  logic [W-1:0] im_c;

  always_comb begin
    im_c = im_i;
    // Negating the most negative value would wrap back onto itself, so clamp it.
    if (mode_i[MODE_CONJ]) begin
      im_c = (im_i == MIN_V) ? MAX_V : -im_i;
    end
    re_o = re_i;
    im_o = im_c;
    if (mode_i[MODE_SWAP]) begin
      re_o = im_c;
      im_o = re_i;
    end
  end

endmodule

// File: rtl/iq_source_switch.sv
// Registered N-way complex sample selector; zero-fills MUTE_LEN valid samples after
// every source change so the demodulator never sees a splice transient.
module iq_source_switch
  import iq_source_switch_pkg::*;
#(
  parameter int W        = 16,
  parameter int NSRC     = 2,
  parameter int MUTE_LEN = 8,
  localparam int SELW    = clog2_min1(NSRC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC*W-1:0] iredata,
  input  logic [NSRC*W-1:0] iimdata,
  input  logic [NSRC-1:0]   ivalid,
  input  logic [SELW-1:0]   sel,
  input  logic [1:0]        mode,
  output logic [W-1:0]      oredata_rx,
  output logic [W-1:0]      oimdata_rx,
  output logic              ovalid,
  output logic              omute,
  output logic [SELW-1:0]   osel_active
);

  localparam int CW = clog2_min1(MUTE_LEN + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUTE_LEN);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SELW-1:0] act_q, act_d;
  logic [W-1:0]    re_q, re_d, im_q, im_d;
  logic            valid_q, valid_d, mute_q, mute_d;

  logic [W-1:0]    src_re, src_im, proc_re, proc_im;
  logic            src_v;
  logic            sel_ok;

  // Strobe semantics: no backpressure. A sample exists on a cycle exactly when its
  // valid bit is high; ovalid marks each registered output sample for one cycle.
  always_comb begin
    src_re = '0;
    src_im = '0;
    src_v  = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (act_q == SELW'(k)) begin
        src_re = iredata[k*W +: W];
        src_im = iimdata[k*W +: W];
        src_v  = ivalid[k];
      end
    end
  end

  assign sel_ok = (32'(sel) < 32'(NSRC));

  iq_conj_swap #(.W(W)) u_conj_swap (
    .re_i  (src_re),
    .im_i  (src_im),
    .mode_i(mode),
    .re_o  (proc_re),
    .im_o  (proc_im)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    re_d    = re_q;
    im_d    = im_q;
    valid_d = src_v;
    mute_d  = (state_q == ST_MUTE);

    if (src_v) begin
      if (state_q == ST_MUTE) begin
        re_d = '0;
        im_d = '0;
        if (cnt_q == CW'(1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end else begin
        re_d = proc_re;
        im_d = proc_im;
      end
    end

    // A switch overrides the countdown above, so a change during MUTE restarts it.
    if (sel_ok && (sel != act_q)) begin
      act_d = sel;
      if (MUTE_LEN > 0) begin
        state_d = ST_MUTE;
        cnt_d   = CNT_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      act_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
      valid_q <= 1'b0;
      mute_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      re_q    <= re_d;
      im_q    <= im_d;
      valid_q <= valid_d;
      mute_q  <= mute_d;
    end
  end

  assign oredata_rx  = re_q;
  assign oimdata_rx  = im_q;
  assign ovalid      = valid_q;
  assign omute       = mute_q;
  assign osel_active = act_q;

endmodule

// File: tb/tb_iq_source_switch.sv
// Bench for iq_source_switch: directed vector table, multi-cycle switch/mute sequences,
// and random traffic, all scored against an integer-arithmetic reference model.
module tb_iq_source_switch;

  localparam int W        = 16;
  localparam int NSRC     = 3;
  localparam int MUTE_LEN = 8;
  localparam int SELW     = 2;
  localparam int SMAX     = (1 << (W-1)) - 1;

  typedef logic [2*W+SELW+1:0] obs_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NSRC*W-1:0] iredata, iimdata;
  logic [NSRC-1:0]   ivalid;
  logic [SELW-1:0]   sel;
  logic [1:0]        mode;
  logic [W-1:0]      oredata_rx, oimdata_rx;
  logic              ovalid, omute;
  logic [SELW-1:0]   osel_active;

  logic [W-1:0]      o0_re, o0_im;
  logic              o0_valid, o0_mute;
  logic [0:0]        o0_sel;

  int   n_chk  = 0;
  int   n_pass = 0;
  obs_t exp_q[$];

  int           m_act, m_rem;
  logic [W-1:0] m_re, m_im;

  // clock / reset
  always #5 clk = ~clk;

  iq_source_switch #(.W(W), .NSRC(NSRC), .MUTE_LEN(MUTE_LEN)) u_dut (
    .clk(clk), .rst(rst), .iredata(iredata), .iimdata(iimdata), .ivalid(ivalid),
    .sel(sel), .mode(mode), .oredata_rx(oredata_rx), .oimdata_rx(oimdata_rx),
    .ovalid(ovalid), .omute(omute), .osel_active(osel_active)
  );

  iq_source_switch #(.W(W), .NSRC(2), .MUTE_LEN(0)) u_dut0 (
    .clk(clk), .rst(rst), .iredata(iredata[2*W-1:0]), .iimdata(iimdata[2*W-1:0]),
    .ivalid(ivalid[1:0]), .sel(sel[0:0]), .mode(mode), .oredata_rx(o0_re),
    .oimdata_rx(o0_im), .ovalid(o0_valid), .omute(o0_mute), .osel_active(o0_sel)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // reference model: tracks the routed source and how many zero samples remain owed
  task automatic model_step();
    int re, im, t;
    logic v, mute;
    v    = ivalid[m_act];
    mute = (m_rem > 0);
    if (v) begin
      if (m_rem > 0) begin
        m_re = '0;
        m_im = '0;
        m_rem--;
      end else begin
        re = $signed(iredata[m_act*W +: W]);
        im = $signed(iimdata[m_act*W +: W]);
        if (mode[0]) begin
          im = -im;
          if (im > SMAX) im = SMAX;
        end
        if (mode[1]) begin
          t  = re;
          re = im;
          im = t;
        end
        m_re = W'(re);
        m_im = W'(im);
      end
    end
    if (int'(sel) < NSRC && int'(sel) != m_act) begin
      m_act = int'(sel);
      m_rem = MUTE_LEN;
    end
    exp_q.push_back({v, mute, SELW'(m_act), m_re, m_im});
  endtask

  function automatic obs_t dut_obs();
    return {ovalid, omute, osel_active, oredata_rx, oimdata_rx};
  endfunction

  // driver tasks
  task automatic set_src(input int k, input int re, input int im);
    iredata[k*W +: W] = W'(re);
    iimdata[k*W +: W] = W'(im);
  endtask

  task automatic cycle(input string name);
    obs_t e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(name, dut_obs(), e);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    ivalid = '0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_act = 0;
    m_rem = 0;
    m_re  = '0;
    m_im  = '0;
    exp_q.delete();
    check("reset", dut_obs(), '0);
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [1:0] mode;
    logic [2:0] val;
    int         re0, im0;
    logic       ev, em;
    logic [1:0] eact;
    int         ere, eim;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int zeros, first_re;
    bit seen;

    tbl[0] = '{2'd0, 2'b00, 3'b001,   100,    -50, 1'b1, 1'b0, 2'd0,  100,    -50};
    tbl[1] = '{2'd0, 2'b01, 3'b001,     3, -32768, 1'b1, 1'b0, 2'd0,    3,  32767};
    tbl[2] = '{2'd0, 2'b11, 3'b001,     5,      7, 1'b1, 1'b0, 2'd0,   -7,      5};
    tbl[3] = '{2'd0, 2'b10, 3'b001,     5,      7, 1'b1, 1'b0, 2'd0,    7,      5};
    tbl[4] = '{2'd0, 2'b00, 3'b000,    99,     99, 1'b0, 1'b0, 2'd0,    7,      5};
    tbl[5] = '{2'd3, 2'b00, 3'b001,    11,     12, 1'b1, 1'b0, 2'd0,   11,     12};
    tbl[6] = '{2'd0, 2'b01, 3'b001,    -1,  32767, 1'b1, 1'b0, 2'd0,   -1, -32767};

    rst = 1'b1; sel = '0; mode = '0; ivalid = '0; iredata = '0; iimdata = '0;
    @(posedge clk);
    #1;
    do_reset();
    set_src(1, 1234, -1234);
    set_src(2, 77, 88);

    // directed vector table
    for (int i = 0; i < 7; i++) begin
      sel    = tbl[i].sel;
      mode   = tbl[i].mode;
      ivalid = tbl[i].val;
      set_src(0, tbl[i].re0, tbl[i].im0);
      cycle($sformatf("tbl%0d_model", i));
      check($sformatf("tbl%0d", i), dut_obs(),
            {tbl[i].ev, tbl[i].em, tbl[i].eact, W'(tbl[i].ere), W'(tbl[i].eim)});
    end

    // switch 0->1: old sample passes unmuted, then 8 zeros, then source-1 data
    mode = 2'b00; sel = 2'd1; ivalid = 3'b001;
    set_src(0, 20, 21);
    cycle("swA_model");
    check("swA_edge", dut_obs(), {1'b1, 1'b0, 2'd1, W'(20), W'(21)});
    zeros = 0; seen = 0; first_re = 0;
    for (int i = 0; i < 20; i++) begin
      ivalid = (i % 2 == 0) ? 3'b010 : 3'b000;
      set_src(1, 1000 + i, -1000 - i);
      cycle("swA_model");
      if (ovalid && omute) zeros++;
      if (ovalid && !omute && !seen) begin
        seen = 1;
        first_re = int'($signed(oredata_rx));
      end
    end
    check("swA_zeros", 64'(zeros), 64'(8));
    check("swA_first", 64'(first_re), 64'(1016));

    // switch 1->0, three muted samples, then back to 1: countdown restarts
    sel = 2'd0; ivalid = 3'b010;
    set_src(1, 555, -555);
    cycle("swB_model");
    check("swB_edge", dut_obs(), {1'b1, 1'b0, 2'd0, W'(555), W'(-555)});
    for (int i = 0; i < 3; i++) begin
      ivalid = 3'b001;
      set_src(0, 40 + i, 41 + i);
      cycle("swB_model");
      check("swB_mute", dut_obs(), {1'b1, 1'b1, 2'd0, W'(0), W'(0)});
    end
    sel = 2'd1; ivalid = 3'b000;
    cycle("swB_model");
    zeros = 0; seen = 0; first_re = 0;
    for (int i = 0; i < 12; i++) begin
      ivalid = 3'b010;
      set_src(1, 2000 + i, 7);
      cycle("swB_model");
      if (ovalid && omute) zeros++;
      if (ovalid && !omute && !seen) begin
        seen = 1;
        first_re = int'($signed(oredata_rx));
      end
    end
    check("swB_zeros", 64'(zeros), 64'(8));
    check("swB_first", 64'(first_re), 64'(2008));

    // out-of-range select while running on source 1
    sel = 2'd3;
    for (int i = 0; i < 4; i++) begin
      ivalid = 3'b010;
      set_src(1, 3000 + i, i);
      cycle("oor_model");
      check("oor", {ovalid, omute, osel_active, oredata_rx}, {1'b1, 1'b0, 2'd1, W'(3000 + i)});
    end

    // reset in the middle of a mute period
    sel = 2'd0; ivalid = 3'b010;
    cycle("rstm_model");
    for (int i = 0; i < 2; i++) begin
      ivalid = 3'b001;
      cycle("rstm_model");
    end
    check("rstm_muting", 64'(omute), 64'(1));
    do_reset();
    check("reset_dut0", {o0_valid, o0_mute, o0_sel, o0_re, o0_im}, '0);

    // no-mute build switches straight to the new source
    sel = 2'd1; ivalid = 3'b011;
    set_src(0, 1, 2);
    set_src(1, 300, 400);
    cycle("m0_model");
    check("m0_edge", {o0_valid, o0_mute, o0_sel, o0_re, o0_im}, {1'b1, 1'b0, 1'b1, W'(1), W'(2)});
    set_src(1, 301, 401);
    cycle("m0_model");
    check("m0_data", {o0_valid, o0_mute, o0_sel, o0_re, o0_im}, {1'b1, 1'b0, 1'b1, W'(301), W'(401)});

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 9) == 0) sel = SELW'($urandom_range(0, 3));
        mode   = 2'($urandom_range(0, 3));
        ivalid = NSRC'($urandom_range(0, 7));
        for (int k = 0; k < NSRC; k++) begin
          set_src(k,
                  ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)),
                  ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)));
        end
        cycle("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
